// File: rtl/fetch_ctrl_if.sv
// Fetch-control bundle: redirect/stall/memory inputs and PC-control outputs.
// The master side is the fetch controller; the slave side is the surrounding pipeline.
interface fetch_ctrl_if;
    logic        hazard_stall;
    logic        redirect_valid;
    logic [1:0]  redirect_op;
    logic [31:0] redirect_imm;
    logic [31:0] redirect_base;
    logic        imem_ready;
    logic        imem_req;
    logic        pc_write_enable;
    logic [1:0]  pc_op;
    logic [31:0] pc_target_addr;
    logic [31:0] pc_jalr_base;
    logic        flush_if_id;
    logic        flush_id_ex;
    logic        stall_timeout;

    modport master (
        input  hazard_stall, redirect_valid, redirect_op, redirect_imm, redirect_base, imem_ready,
        output imem_req, pc_write_enable, pc_op, pc_target_addr, pc_jalr_base,
        output flush_if_id, flush_id_ex, stall_timeout
    );

    modport slave (
        output hazard_stall, redirect_valid, redirect_op, redirect_imm, redirect_base, imem_ready,
        input  imem_req, pc_write_enable, pc_op, pc_target_addr, pc_jalr_base,
        input  flush_if_id, flush_id_ex, stall_timeout
    );
endinterface

// File: rtl/fetch_ctrl.sv
// Instruction-fetch controller: sequences PC updates, redirects, stalls and pipeline flushes,
// with a sticky watchdog for long runs of cycles without a PC update.
module fetch_ctrl #(
    parameter int unsigned BOOT_CYCLES = 2,
    parameter int unsigned MAX_STALL   = 16
) (
    input  logic         clk,
    input  logic         rst,
    fetch_ctrl_if.master bus
);
    localparam int unsigned BOOT_W    = (BOOT_CYCLES > 1) ? $clog2(BOOT_CYCLES) : 1;
    localparam int unsigned BOOT_LAST = (BOOT_CYCLES > 0) ? BOOT_CYCLES - 1 : 0;
    localparam int unsigned CNT_W     = 8;
    localparam int unsigned LIMIT     = (MAX_STALL > 255) ? 255 : MAX_STALL;
    localparam logic [CNT_W-1:0] CNT_MAX     = '1;
    localparam logic [CNT_W-1:0] STALL_LIMIT = CNT_W'(LIMIT);

    typedef enum logic [1:0] {
        BOOT       = 2'd0,
        RUN        = 2'd1,
        MEM_WAIT   = 2'd2,
        REDIR_PEND = 2'd3
    } state_t;

    state_t            state_q, state_d;
    logic [BOOT_W-1:0] boot_cnt_q;
    logic [CNT_W-1:0]  stall_cnt_q, stall_cnt_d;
    logic              timeout_q, timeout_c;
    logic [1:0]        pend_op_q;
    logic [31:0]       pend_imm_q, pend_base_q;
    logic              pend_load;

    logic        req_c, we_c, flush_if_c, flush_ex_c;
    logic [1:0]  op_c;
    logic [31:0] tgt_c, base_c;
    logic        redir_legal;

    assign redir_legal = bus.redirect_valid && (bus.redirect_op != 2'b00);

    // Next state and same-cycle PC control; RUN and MEM_WAIT share the fetch rules.
    always_comb begin
        state_d    = state_q;
        req_c      = 1'b0;
        we_c       = 1'b0;
        op_c       = 2'b00;
        tgt_c      = '0;
        base_c     = '0;
        flush_if_c = 1'b0;
        flush_ex_c = 1'b0;
        pend_load  = 1'b0;
        case (state_q)
            BOOT: begin
                if (boot_cnt_q == BOOT_W'(BOOT_LAST)) state_d = RUN;
            end
            REDIR_PEND: begin
                // Held redirect wins over everything until memory accepts it.
                req_c  = 1'b1;
                op_c   = pend_op_q;
                tgt_c  = pend_imm_q;
                base_c = pend_base_q;
                if (bus.imem_ready) begin
                    we_c    = 1'b1;
                    state_d = RUN;
                end
            end
            default: begin
                req_c = 1'b1;
                if (redir_legal) begin
                    flush_if_c = 1'b1;
                    flush_ex_c = 1'b1;
                    if (bus.imem_ready) begin
                        we_c    = 1'b1;
                        op_c    = bus.redirect_op;
                        tgt_c   = bus.redirect_imm;
                        base_c  = bus.redirect_base;
                        state_d = RUN;
                    end else begin
                        pend_load = 1'b1;
                        state_d   = REDIR_PEND;
                    end
                end else if (bus.hazard_stall) begin
                    flush_ex_c = 1'b1;
                    if (bus.imem_ready) state_d = RUN;
                end else if (!bus.imem_ready) begin
                    flush_if_c = 1'b1;
                    state_d    = MEM_WAIT;
                end else begin
                    we_c    = 1'b1;
                    state_d = RUN;
                end
            end
        endcase
    end

    // Saturating count of non-updating cycles; the flag rises in the cycle the limit is reached.
    always_comb begin
        stall_cnt_d = stall_cnt_q;
        timeout_c   = timeout_q;
        if (state_q != BOOT) begin
            if (we_c) begin
                stall_cnt_d = '0;
            end else begin
                if (stall_cnt_q != CNT_MAX) stall_cnt_d = stall_cnt_q + CNT_W'(1);
                if (stall_cnt_d >= STALL_LIMIT) timeout_c = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= BOOT;
            boot_cnt_q  <= '0;
            stall_cnt_q <= '0;
            timeout_q   <= 1'b0;
            pend_op_q   <= 2'b00;
            pend_imm_q  <= '0;
            pend_base_q <= '0;
        end else begin
            state_q     <= state_d;
            stall_cnt_q <= stall_cnt_d;
            timeout_q   <= timeout_c;
            if (state_q == BOOT) boot_cnt_q <= boot_cnt_q + BOOT_W'(1);
            if (pend_load) begin
                pend_op_q   <= bus.redirect_op;
                pend_imm_q  <= bus.redirect_imm;
                pend_base_q <= bus.redirect_base;
            end
        end
    end

    assign bus.imem_req        = req_c;
    assign bus.pc_write_enable = we_c;
    assign bus.pc_op           = op_c;
    assign bus.pc_target_addr  = tgt_c;
    assign bus.pc_jalr_base    = base_c;
    assign bus.flush_if_id     = flush_if_c;
    assign bus.flush_id_ex     = flush_ex_c;
    assign bus.stall_timeout   = timeout_c;
endmodule

// File: tb/tb_fetch_ctrl.sv
// Bench for fetch_ctrl: directed scenarios plus random traffic against a cycle-level
// reference model of boot delay, redirect hold-over, stall/fetch rules and the watchdog.
module tb_fetch_ctrl;
    localparam int unsigned BOOT_CYCLES = 2;
    localparam int unsigned MAX_STALL   = 16;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    fetch_ctrl_if bus ();

    fetch_ctrl #(.BOOT_CYCLES(BOOT_CYCLES), .MAX_STALL(MAX_STALL)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    logic [70:0] got;
    logic [70:0] exp;
    assign got = {bus.imem_req, bus.pc_write_enable, bus.pc_op, bus.pc_target_addr,
                  bus.pc_jalr_base, bus.flush_if_id, bus.flush_id_ex, bus.stall_timeout};

    // Current stimulus
    logic        i_hs, i_rv, i_rdy;
    logic [1:0]  i_op;
    logic [31:0] i_imm, i_base;

    // Reference model state
    int          boot_left;
    int          stalls;
    bit          sticky;
    bit          pend;
    logic [1:0]  p_op;
    logic [31:0] p_imm, p_base;
    // Model results for the current cycle
    bit          n_pend, n_latch, e_we, e_to;
    int          n_stalls;

    task automatic model_reset();
        boot_left = BOOT_CYCLES;
        stalls    = 0;
        sticky    = 0;
        pend      = 0;
        p_op      = 2'b00;
        p_imm     = '0;
        p_base    = '0;
    endtask

    // Expected outputs from the current inputs and model state.
    task automatic model_eval();
        logic r, w, fi, fd;
        logic [1:0] o;
        logic [31:0] t, b;
        r = 0; w = 0; fi = 0; fd = 0; o = 2'b00; t = '0; b = '0;
        n_pend = 0; n_latch = 0;
        if (rst || boot_left > 0) begin
            exp = '0; e_we = 0; e_to = sticky; n_stalls = stalls;
            return;
        end
        r = 1;
        if (pend) begin
            w = i_rdy; o = p_op; t = p_imm; b = p_base;
            n_pend = !i_rdy;
        end else if (i_rv && i_op != 2'b00) begin
            fi = 1; fd = 1; w = i_rdy;
            if (i_rdy) begin
                o = i_op; t = i_imm; b = i_base;
            end else begin
                n_pend = 1; n_latch = 1;
            end
        end else if (i_hs) begin
            fd = 1;
        end else if (!i_rdy) begin
            fi = 1;
        end else begin
            w = 1;
        end
        n_stalls = w ? 0 : ((stalls < 255) ? stalls + 1 : 255);
        e_to = sticky || (!w && n_stalls >= int'(MAX_STALL));
        e_we = w;
        exp = {r, w, o, t, b, fi, fd, e_to};
    endtask

    task automatic model_update();
        if (rst) return;
        if (boot_left > 0) begin
            boot_left--;
            return;
        end
        stalls = n_stalls;
        sticky = e_to;
        pend   = n_pend;
        if (n_latch) begin
            p_op = i_op; p_imm = i_imm; p_base = i_base;
        end
    endtask

    task automatic drive(input logic hs, input logic rv, input logic [1:0] op,
                         input logic [31:0] imm, input logic [31:0] base, input logic rdy);
        @(negedge clk);
        i_hs = hs; i_rv = rv; i_op = op; i_imm = imm; i_base = base; i_rdy = rdy;
        bus.hazard_stall   = hs;
        bus.redirect_valid = rv;
        bus.redirect_op    = op;
        bus.redirect_imm   = imm;
        bus.redirect_base  = base;
        bus.imem_ready     = rdy;
        #1;
        model_eval();
    endtask

    task automatic advance();
        @(posedge clk);
        model_update();
        cyc++;
    endtask

    task automatic test_reset();
        drive(1'b1, 1'b1, 2'b11, 32'hdead_beef, 32'h1234_5678, 1'b1);
        checks++;
        if (got !== 71'd0) begin
            errors++;
            $display("FAIL reset_hold got=%h expected=0", got);
        end
        @(posedge clk);
        #2;
        rst = 1'b0;
        model_reset();
    endtask

    task automatic test_boot();
        for (int k = 0; k < 6; k++) begin
            drive(1'b0, 1'b0, 2'b00, 32'h0, 32'h0, 1'b1);
            checks++;
            if (got !== exp) begin
                errors++;
                $display("FAIL boot cyc=%0d got=%h expected=%h", cyc, got, exp);
            end
            checks++;
            if (bus.pc_write_enable !== ((k >= 2) ? 1'b1 : 1'b0)) begin
                errors++;
                $display("FAIL boot_we k=%0d got=%b", k, bus.pc_write_enable);
            end
            advance();
        end
    endtask

    task automatic test_redirect_ready();
        logic [31:0] base;
        base = $urandom;
        drive(1'b0, 1'b1, 2'b10, 32'h10, base, 1'b1);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL redirect_ready cyc=%0d got=%h expected=%h", cyc, got, exp);
        end
        checks++;
        if (got !== {1'b1, 1'b1, 2'b10, 32'h10, base, 1'b1, 1'b1, 1'b0}) begin
            errors++;
            $display("FAIL redirect_ready_direct got=%h", got);
        end
        advance();
        drive(1'b0, 1'b0, 2'b00, 32'h0, 32'h0, 1'b1);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL redirect_after cyc=%0d got=%h expected=%h", cyc, got, exp);
        end
        advance();
    endtask

    task automatic test_redirect_pending();
        drive(1'b0, 1'b1, 2'b11, 32'h4, 32'h1000, 1'b0);
        for (int k = 0; k < 5; k++) begin
            if (k > 0)
                drive(1'($urandom_range(1, 0)), 1'b1, 2'b01, $urandom, $urandom, (k >= 3) ? 1'b1 : 1'b0);
            checks++;
            if (got !== exp) begin
                errors++;
                $display("FAIL redirect_pending k=%0d got=%h expected=%h", k, got, exp);
            end
            if (k == 1 || k == 2) begin
                checks++;
                if (bus.pc_op !== 2'b11 || bus.pc_jalr_base !== 32'h1000 || bus.pc_write_enable !== 1'b0) begin
                    errors++;
                    $display("FAIL pend_hold k=%0d op=%b base=%h we=%b", k, bus.pc_op, bus.pc_jalr_base, bus.pc_write_enable);
                end
            end
            if (k == 3) begin
                checks++;
                if (bus.pc_write_enable !== 1'b1 || bus.pc_target_addr !== 32'h4) begin
                    errors++;
                    $display("FAIL pend_release we=%b tgt=%h", bus.pc_write_enable, bus.pc_target_addr);
                end
            end
            advance();
        end
    endtask

    task automatic test_stall_priority();
        drive(1'b1, 1'b1, 2'b01, 32'h0000_0040, 32'h0, 1'b1);
        checks++;
        if (got !== exp || bus.pc_op !== 2'b01 || bus.flush_if_id !== 1'b1 || bus.flush_id_ex !== 1'b1) begin
            errors++;
            $display("FAIL stall_vs_redirect got=%h expected=%h", got, exp);
        end
        advance();
        drive(1'b1, 1'b0, 2'b00, 32'h0, 32'h0, 1'b1);
        checks++;
        if (got !== exp || bus.pc_write_enable !== 1'b0 || bus.flush_id_ex !== 1'b1 || bus.flush_if_id !== 1'b0) begin
            errors++;
            $display("FAIL stall_alone got=%h expected=%h", got, exp);
        end
        advance();
        drive(1'b1, 1'b1, 2'b00, 32'h8, 32'h8, 1'b1);
        checks++;
        if (got !== exp || bus.pc_op !== 2'b00 || bus.flush_if_id !== 1'b0) begin
            errors++;
            $display("FAIL illegal_op got=%h expected=%h", got, exp);
        end
        advance();
        drive(1'b0, 1'b0, 2'b00, 32'h0, 32'h0, 1'b1);
        advance();
    endtask

    task automatic test_timeout();
        for (int k = 1; k <= 20; k++) begin
            drive((k <= 16) ? 1'b1 : 1'b0, 1'b0, 2'b00, 32'h0, 32'h0, 1'b1);
            checks++;
            if (got !== exp || bus.stall_timeout !== ((k >= 16) ? 1'b1 : 1'b0)) begin
                errors++;
                $display("FAIL timeout k=%0d flag=%b got=%h expected=%h", k, bus.stall_timeout, got, exp);
            end
            advance();
        end
    endtask

    task automatic test_reset_in_pend();
        drive(1'b0, 1'b1, 2'b11, 32'hc, 32'h2000, 1'b0);
        advance();
        drive(1'b0, 1'b0, 2'b00, 32'h0, 32'h0, 1'b0);
        checks++;
        if (bus.pc_op !== 2'b11 || bus.pc_jalr_base !== 32'h2000) begin
            errors++;
            $display("FAIL pend_before_rst op=%b base=%h", bus.pc_op, bus.pc_jalr_base);
        end
        #2;
        rst = 1'b1;
        #1;
        checks++;
        if (got !== 71'd0) begin
            errors++;
            $display("FAIL async_rst got=%h expected=0", got);
        end
        @(posedge clk);
        #2;
        rst = 1'b0;
        model_reset();
        for (int k = 0; k < 4; k++) begin
            drive(1'b0, 1'b0, 2'b00, 32'h0, 32'h0, 1'b1);
            checks++;
            if (got !== exp) begin
                errors++;
                $display("FAIL reboot k=%0d got=%h expected=%h", k, got, exp);
            end
            if (k == 2) begin
                checks++;
                if (bus.pc_write_enable !== 1'b1 || bus.pc_op !== 2'b00 || bus.pc_jalr_base !== 32'h0) begin
                    errors++;
                    $display("FAIL stale_redirect we=%b op=%b", bus.pc_write_enable, bus.pc_op);
                end
            end
            advance();
        end
    endtask

    task automatic test_random();
        for (int k = 0; k < 400; k++) begin
            drive(($urandom_range(3, 0) == 0), ($urandom_range(3, 0) == 0), 2'($urandom_range(3, 0)),
                  $urandom, $urandom, ($urandom_range(3, 0) != 0));
            checks++;
            if (got !== exp) begin
                errors++;
                $display("FAIL random cyc=%0d got=%h expected=%h", cyc, got, exp);
            end
            advance();
        end
    endtask

    initial begin
        bus.hazard_stall   = 1'b0;
        bus.redirect_valid = 1'b0;
        bus.redirect_op    = 2'b00;
        bus.redirect_imm   = '0;
        bus.redirect_base  = '0;
        bus.imem_ready     = 1'b0;
        model_reset();
        test_reset();
        test_boot();
        test_redirect_ready();
        test_redirect_pending();
        test_stall_priority();
        test_timeout();
        test_reset_in_pend();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/fetch_ctrl.md
FETCH_CTRL -- requirements
Module: fetch_ctrl

Interface
REQ-001 The block SHALL have parameter BOOT_CYCLES, default 2, meaning the number of idle cycles after reset before the first fetch.
REQ-002 The block SHALL have parameter MAX_STALL, default 16, meaning the consecutive-stall count that sets the watchdog flag.
REQ-003 The block SHALL have the following ports (name, direction, width, meaning):
- clk  in  1  single clock; all state updates on its rising edge
- rst  in  1  asynchronous, active-high reset
- hazard_stall  in  1  load-use stall request from the hazard unit
- redirect_valid  in  1  control transfer resolved in EX
- redirect_op  in  2  01 JAL, 10 branch, 11 JALR; 00 is illegal
- redirect_imm  in  32  signed offset of the transfer
- redirect_base  in  32  x[rs1] for JALR
- imem_ready  in  1  instruction memory has accepted/returned the current fetch
- imem_req  out  1  fetch request to instruction memory
- pc_write_enable  out  1  PC register update enable
- pc_op  out  2  PC next-value select: 00 PC+4, 01 JAL, 10 branch, 11 JALR
- pc_target_addr  out  32  offset presented to the PC
- pc_jalr_base  out  32  JALR base presented to the PC
- flush_if_id  out  1  invalidate the IF/ID register
- flush_id_ex  out  1  insert a bubble into ID/EX
- stall_timeout  out  1  sticky watchdog flag

Function
REQ-004 The FSM SHALL have four states: BOOT, RUN, MEM_WAIT, REDIR_PEND.
REQ-005 In BOOT, the block SHALL hold imem_req=0 and pc_write_enable=0, count BOOT_CYCLES cycles, then enter RUN.
REQ-006 In RUN, MEM_WAIT and REDIR_PEND, imem_req SHALL be 1.
REQ-007 Outputs SHALL be combinational from the current state, inputs and registers, so that the PC updates on the same edge.
REQ-008 Priority SHALL be: a pending redirect, then redirect_valid, then hazard_stall, then sequential fetch.
REQ-009 In RUN, when redirect_valid=1, redirect_op!=00 and imem_ready=1, the block SHALL drive:
- pc_write_enable=1
- pc_op=redirect_op
- pc_target_addr=redirect_imm
- pc_jalr_base=redirect_base
- flush_if_id=1 and flush_id_ex=1 for that one cycle
The FSM SHALL stay in RUN.
REQ-010 In RUN, when a legal redirect arrives with imem_ready=0, the block SHALL:
- latch op, imm and base into pending registers
- assert both flushes that cycle
- enter REDIR_PEND
REQ-011 In REDIR_PEND, the block SHALL drive the pending registers onto pc_op, pc_target_addr and pc_jalr_base. On the first cycle with imem_ready=1 it SHALL assert pc_write_enable=1 and return to RUN. A new redirect_valid in this state SHALL be ignored.
REQ-012 A redirect with redirect_op=00 SHALL be treated as no redirect.
REQ-013 A redirect SHALL override hazard_stall in the same cycle.
REQ-014 When hazard_stall=1 with no redirect, the block SHALL drive:
- pc_write_enable=0
- flush_id_ex=1
- flush_if_id=0
REQ-015 When imem_ready=0 in RUN with no redirect, the block SHALL drive pc_write_enable=0 and flush_if_id=1, and enter MEM_WAIT.
REQ-016 MEM_WAIT SHALL return to RUN on the cycle imem_ready=1. That cycle SHALL apply the normal RUN rules (REQ-009, REQ-013, REQ-014, sequential fetch).
REQ-017 Sequential fetch (RUN, imem_ready=1, no stall, no redirect) SHALL drive pc_write_enable=1, pc_op=00 and no flushes.
REQ-018 In every state other than REDIR_PEND, pc_target_addr and pc_jalr_base SHALL be 0 whenever no redirect is being applied.
REQ-019 An 8-bit saturating stall counter SHALL:
- increment on each cycle with pc_write_enable=0 outside BOOT
- clear on any cycle with pc_write_enable=1
REQ-020 When the stall counter reaches MAX_STALL, stall_timeout SHALL be set and SHALL remain set until rst.

Reset
REQ-021 While rst=1, the block SHALL hold the following values, asynchronously:
- state=BOOT
- all counters and pending registers 0
- stall_timeout=0
- imem_req=0, pc_write_enable=0, pc_op=00
- pc_target_addr=0, pc_jalr_base=0
- both flushes 0
REQ-022 A reset asserted mid-operation, including in REDIR_PEND, SHALL discard any pending redirect. After release, BOOT SHALL be re-entered.

Verification
REQ-023 Release rst, imem_ready=1 -> no write_enable for 2 cycles, then pc_write_enable=1, pc_op=00 every cycle.
REQ-024 RUN; redirect_valid=1, op=10, imm=0x10, imem_ready=1 -> same cycle pc_op=10, pc_target_addr=0x10, write_enable=1, both flushes=1.
REQ-025 RUN; op=11, base=0x1000, imm=4, imem_ready=0 for 3 cycles -> REDIR_PEND, pc_op=11 held, write_enable only on the cycle imem_ready rises, then RUN.
REQ-026 hazard_stall=1 and redirect op=01 in the same cycle -> redirect applied, flushes=1; with the stall alone, write_enable=0 and flush_id_ex=1.
REQ-027 hazard_stall held 16 cycles -> stall_timeout=1 on the 16th cycle, stays 1 after the stall is removed until rst.
REQ-028 Assert rst during REDIR_PEND -> all outputs 0 immediately; after release, BOOT lasts 2 cycles and no stale redirect is applied.
